smi_fuzz_test_sequencer: RTL and testbench

SMI_FUZZ_TEST_SEQUENCER -- requirements
Module: smi_fuzz_test_sequencer

---
 rtl/smi_fuzz_pkg.sv | 26 ++
 rtl/smi_fuzz_watchdog.sv | 27 ++
 rtl/smi_fuzz_test_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_smi_fuzz_test_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_fuzz_pkg.sv
// Shared types for the fuzz test sequencer: FSM state encoding, test modes
// and the burst-length alignment mask.
package smi_fuzz_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_COUNT    = 3'd2,
    ST_START_WR = 3'd3,
    ST_WAIT_WR  = 3'd4,
    ST_START_RD = 3'd5,
    ST_WAIT_RD  = 3'd6,
    ST_REPORT   = 3'd7
  } stateT;

  localparam logic [1:0] MODE_WR_RD     = 2'd0;
  localparam logic [1:0] MODE_WR_ONLY   = 2'd1;
  localparam logic [1:0] MODE_RD_ONLY   = 2'd2;
  localparam logic [1:0] MODE_WR_RD_ALT = 2'd3;

  // Clears the sub-word bits so only whole bus words are counted.
  function automatic logic [31:0] byteMask(input int unsigned dataBytes);
    byteMask = ~((32'd1 << $clog2(dataBytes)) - 32'd1);
  endfunction

endpackage

// File: rtl/smi_fuzz_watchdog.sv
// Per-wait cycle counter: cleared outside the wait, counts while enabled and
// flags expiry on the last allowed cycle.
module smi_fuzz_watchdog #(
  parameter int unsigned LIMIT = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] cycleCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= '0;
    end else if (clr) begin
      cycleCnt <= '0;
    end else if (en) begin
      cycleCnt <= cycleCnt + 32'd1;
    end
  end

  assign expired = en && (cycleCnt == (LIMIT - 32'd1));

endmodule

// File: rtl/smi_fuzz_test_sequencer.sv
// Fuzz test sequencer: pops burst parameters, launches write/read legs and
// reports error/byte totals. Optional watchdog via SMI_FUZZ_WATCHDOG_EN.
//
// state     | meaning
// RESET     | held in reset, leaves on the first cycle after release
// IDLE      | ready for a new configuration, counters cleared
// COUNT     | waits for burst parameters or finishes the run
// START_WR  | launches the write source
// WAIT_WR   | waits for write completion
// START_RD  | launches the read checker
// WAIT_RD   | waits for read completion
// REPORT    | presents the result until accepted
module smi_fuzz_test_sequencer
  import smi_fuzz_pkg::*;
#(
  parameter int unsigned DATA_BYTES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_stop,
  input  logic [31:0] cfg_num_tests,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_stop_on_error,
  input  logic        param_valid,
  output logic        param_stop,
  input  logic [31:0] param_byte_len,
  output logic        wr_start_valid,
  input  logic        wr_start_stop,
  input  logic        wr_done_valid,
  input  logic        wr_done_ok,
  output logic        wr_done_stop,
  output logic        rd_start_valid,
  input  logic        rd_start_stop,
  input  logic        rd_done_valid,
  input  logic        rd_done_ok,
  output logic        rd_done_stop,
  output logic        status_valid,
  input  logic        status_stop,
  output logic [31:0] status_errors,
  output logic [15:0] status_timeouts,
  output logic [63:0] status_data_count
);

  localparam logic [31:0] LenMask = byteMask(DATA_BYTES);

  if (!(DATA_BYTES == 8 || DATA_BYTES == 16 || DATA_BYTES == 32)) begin : gBadDataBytes
    $error("DATA_BYTES must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  stateT       state, nextState;
  logic [31:0] testsLeft;
  logic [31:0] errCnt;
  logic [63:0] dataCnt;
  logic [1:0]  modeLat;
  logic        stopOnErrLat;
  logic        wdExpired;
  logic        testEnd, testFail, goRd, stopNow;

`ifdef SMI_FUZZ_WATCHDOG_EN
  logic        inWait, toHit;
  logic [15:0] toCnt;

  assign inWait = (state == ST_WAIT_WR) || (state == ST_WAIT_RD);

  smi_fuzz_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!inWait),
    .en      (inWait),
    .expired (wdExpired)
  );

  // A done arriving on the expiry cycle wins, so it is not a timeout.
  assign toHit = wdExpired && !((state == ST_WAIT_WR) ? wr_done_valid : rd_done_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt <= '0;
    end else if (state == ST_IDLE) begin
      toCnt <= '0;
    end else if (toHit && (toCnt != 16'hFFFF)) begin
      toCnt <= toCnt + 16'd1;
    end
  end

  assign status_timeouts = toCnt;
`else
  assign wdExpired       = 1'b0;
  assign status_timeouts = '0;
`endif

  always_comb begin
    testEnd  = 1'b0;
    testFail = 1'b0;
    goRd     = 1'b0;
    case (state)
      ST_WAIT_WR: begin
        if (wr_done_valid) begin
          if (wr_done_ok && (modeLat != MODE_WR_ONLY)) begin
            goRd = 1'b1;
          end else begin
            testEnd  = 1'b1;
            testFail = !wr_done_ok;
          end
        end else if (wdExpired) begin
          testEnd  = 1'b1;
          testFail = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (rd_done_valid) begin
          testEnd  = 1'b1;
          testFail = !rd_done_ok;
        end else if (wdExpired) begin
          testEnd  = 1'b1;
          testFail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stopNow = stopOnErrLat && ((errCnt != '0) || testFail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_RESET: nextState = ST_IDLE;
      ST_IDLE:  if (cfg_valid) nextState = ST_COUNT;
      ST_COUNT: begin
        if (testsLeft == '0) begin
          nextState = ST_REPORT;
        end else if (param_valid) begin
          nextState = (modeLat == MODE_RD_ONLY) ? ST_START_RD : ST_START_WR;
        end
      end
      ST_START_WR: if (!wr_start_stop) nextState = ST_WAIT_WR;
      ST_WAIT_WR: begin
        if (goRd) begin
          nextState = ST_START_RD;
        end else if (testEnd) begin
          nextState = stopNow ? ST_REPORT : ST_COUNT;
        end
      end
      ST_START_RD: if (!rd_start_stop) nextState = ST_WAIT_RD;
      ST_WAIT_RD:  if (testEnd) nextState = stopNow ? ST_REPORT : ST_COUNT;
      ST_REPORT:   if (!status_stop) nextState = ST_IDLE;
      default:     nextState = ST_RESET;
    endcase
  end

  always_comb begin
    cfg_stop       = 1'b1;
    param_stop     = 1'b1;
    wr_start_valid = 1'b0;
    rd_start_valid = 1'b0;
    wr_done_stop   = 1'b1;
    rd_done_stop   = 1'b1;
    status_valid   = 1'b0;
    case (state)
      ST_IDLE:     cfg_stop = 1'b0;
      ST_START_WR: wr_start_valid = 1'b1;
      ST_WAIT_WR: begin
        wr_done_stop = 1'b0;
        param_stop   = !testEnd;
      end
      ST_START_RD: rd_start_valid = 1'b1;
      ST_WAIT_RD: begin
        rd_done_stop = 1'b0;
        param_stop   = !testEnd;
      end
      ST_REPORT:   status_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      testsLeft    <= '0;
      errCnt       <= '0;
      dataCnt      <= '0;
      modeLat      <= MODE_WR_RD;
      stopOnErrLat <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          testsLeft    <= cfg_num_tests;
          errCnt       <= '0;
          dataCnt      <= '0;
          modeLat      <= cfg_mode;
          stopOnErrLat <= cfg_stop_on_error;
        end
        ST_COUNT: begin
          if ((testsLeft != '0) && param_valid) begin
            testsLeft <= testsLeft - 32'd1;
            dataCnt   <= dataCnt + {32'd0, param_byte_len & LenMask};
          end
        end
        default: begin
          if (testFail) errCnt <= errCnt + 32'd1;
        end
      endcase
    end
  end

  assign status_errors     = errCnt;
  assign status_data_count = dataCnt;

endmodule

// File: tb/tb_smi_fuzz_test_sequencer.sv
// Directed bench for the fuzz test sequencer: a transaction-level model
// predicts the handshake event order and final totals of each run.
`timescale 1ns/1ps
module tb_smi_fuzz_test_sequencer;

  localparam int DB = 16;
  localparam int TO = 16;
  localparam int EV_WS = 1, EV_WD = 2, EV_RS = 3, EV_RD = 4, EV_POP = 5, EV_ST = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_stop, cfg_stop_on_error;
  logic [31:0] cfg_num_tests;
  logic [1:0]  cfg_mode;
  logic        param_valid, param_stop;
  logic [31:0] param_byte_len;
  logic        wr_start_valid, wr_start_stop, wr_done_valid, wr_done_ok, wr_done_stop;
  logic        rd_start_valid, rd_start_stop, rd_done_valid, rd_done_ok, rd_done_stop;
  logic        status_valid, status_stop;
  logic [31:0] status_errors;
  logic [15:0] status_timeouts;
  logic [63:0] status_data_count;

  always #5 clk = ~clk;

  smi_fuzz_test_sequencer #(.DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_stop(cfg_stop), .cfg_num_tests(cfg_num_tests),
    .cfg_mode(cfg_mode), .cfg_stop_on_error(cfg_stop_on_error),
    .param_valid(param_valid), .param_stop(param_stop), .param_byte_len(param_byte_len),
    .wr_start_valid(wr_start_valid), .wr_start_stop(wr_start_stop),
    .wr_done_valid(wr_done_valid), .wr_done_ok(wr_done_ok), .wr_done_stop(wr_done_stop),
    .rd_start_valid(rd_start_valid), .rd_start_stop(rd_start_stop),
    .rd_done_valid(rd_done_valid), .rd_done_ok(rd_done_ok), .rd_done_stop(rd_done_stop),
    .status_valid(status_valid), .status_stop(status_stop),
    .status_errors(status_errors), .status_timeouts(status_timeouts),
    .status_data_count(status_data_count)
  );

  int total = 0, bad = 0;
  int tLen[8];
  bit tWrOk[8], tRdOk[8];
  bit wrHang = 0;
  int expQ[$];
  int expErr, expTo;
  longint unsigned expData;
  int popCnt, wsCnt, rsCnt, wsCyc, popCyc;
  logic [31:0] lastErr;
  logic [63:0] lastData;
  logic [15:0] lastTo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setTests(input int l0, input int l1, input int l2, input int l3, input int l4);
    tLen[0] = l0; tLen[1] = l1; tLen[2] = l2; tLen[3] = l3; tLen[4] = l4;
    tLen[5] = 0; tLen[6] = 0; tLen[7] = 0;
    for (int i = 0; i < 8; i++) begin
      tWrOk[i] = 1'b1;
      tRdOk[i] = 1'b1;
    end
  endtask

  // Transaction model: what each test must do, in order, and the final totals.
  task automatic buildExpect(input int n, input int mode, input bit stopOnErr);
    bit fail, rdOnly, wrOnly, doRead;
    expQ.delete();
    expErr = 0; expTo = 0; expData = 0;
    rdOnly = (mode == 2);
    wrOnly = (mode == 1);
    for (int i = 0; i < n; i++) begin
      fail = 0;
      doRead = rdOnly;
      expData += longint'((tLen[i] / DB) * DB);
      if (!rdOnly) begin
        expQ.push_back(EV_WS);
        if (wrHang) begin
          fail = 1;
          expTo++;
        end else begin
          expQ.push_back(EV_WD);
          if (!tWrOk[i]) fail = 1;
          else if (!wrOnly) doRead = 1;
        end
      end
      if (doRead) begin
        expQ.push_back(EV_RS);
        expQ.push_back(EV_RD);
        if (!tRdOk[i]) fail = 1;
      end
      expQ.push_back(EV_POP);
      if (fail) expErr++;
      if (stopOnErr && expErr > 0) break;
    end
    expQ.push_back(EV_ST);
  endtask

  task automatic runSeq(input int n, input int mode, input bit stopOnErr, input bit abortAtRs);
    int cyc, wrCd, rdCd, idx;
    bit accepted, stSeen, finished;
    int ev[$];
    buildExpect(n, mode, stopOnErr);
    popCnt = 0; wsCnt = 0; rsCnt = 0; wsCyc = -1; popCyc = -1;
    accepted = 0;
    cyc = 0;
    while (!accepted && cyc < 20) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_num_tests = n;
      cfg_mode = mode[1:0];
      cfg_stop_on_error = stopOnErr;
      param_valid = 1'b1;
      wr_done_valid = 1'b0;
      rd_done_valid = 1'b0;
      status_stop = 1'b1;
      #1;
      if (cfg_stop === 1'b0) accepted = 1;
      cyc++;
    end
    check("cfg_accept", accepted, 1);
    wrCd = -1; rdCd = -1; stSeen = 0; finished = 0; cyc = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      idx = (popCnt < 8) ? popCnt : 7;
      cfg_valid = 1'b0;
      param_byte_len = tLen[idx];
      wr_start_stop = (cyc % 3 == 1);
      rd_start_stop = (cyc % 4 == 2);
      wr_done_valid = (wrCd == 0);
      wr_done_ok = tWrOk[idx];
      rd_done_valid = (rdCd == 0);
      rd_done_ok = tRdOk[idx];
      status_stop = !stSeen;
      #1;
      ev.delete();
      if (wr_done_valid && !wr_done_stop) ev.push_back(EV_WD);
      if (rd_done_valid && !rd_done_stop) ev.push_back(EV_RD);
      if (!param_stop) ev.push_back(EV_POP);
      if (wr_start_valid && !wr_start_stop) ev.push_back(EV_WS);
      if (rd_start_valid && !rd_start_stop) ev.push_back(EV_RS);
      if (status_valid && !status_stop) ev.push_back(EV_ST);
      check("cfg_stop_busy", cfg_stop, 1);
      if (status_valid) begin
        check("status_errors", status_errors, expErr);
        check("status_data_count", status_data_count, expData);
        check("status_timeouts", status_timeouts, expTo);
        lastErr = status_errors;
        lastData = status_data_count;
        lastTo = status_timeouts;
        stSeen = 1;
      end
      foreach (ev[k]) begin
        if (expQ.size() == 0) begin
          check("unexpected_event", ev[k], 0);
        end else begin
          check("event_order", ev[k], expQ[0]);
          void'(expQ.pop_front());
        end
        case (ev[k])
          EV_WS: begin wsCnt++; wsCyc = cyc; wrCd = wrHang ? -1 : 2; end
          EV_WD: wrCd = -1;
          EV_RS: begin
            rsCnt++;
            rdCd = abortAtRs ? -1 : 1;
            if (abortAtRs) finished = 1;
          end
          EV_RD: rdCd = -1;
          EV_POP: begin popCnt++; popCyc = cyc; end
          EV_ST: finished = 1;
          default: ;
        endcase
      end
      if (wrCd > 0) wrCd--;
      if (rdCd > 0) rdCd--;
      cyc++;
    end
    check("run_finished", finished, 1);
    if (!abortAtRs) check("events_left", expQ.size(), 0);
  endtask

  task automatic checkResetOutputs();
    check("rst_cfg_stop", cfg_stop, 1);
    check("rst_param_stop", param_stop, 1);
    check("rst_wr_done_stop", wr_done_stop, 1);
    check("rst_rd_done_stop", rd_done_stop, 1);
    check("rst_valids", {wr_start_valid, rd_start_valid, status_valid}, 0);
    check("rst_errors", status_errors, 0);
    check("rst_data_count", status_data_count, 0);
    check("rst_timeouts", status_timeouts, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_valid = 0; cfg_num_tests = 0; cfg_mode = 0; cfg_stop_on_error = 0;
    param_valid = 0; param_byte_len = 0;
    wr_start_stop = 1; wr_done_valid = 0; wr_done_ok = 0;
    rd_start_stop = 1; rd_done_valid = 0; rd_done_ok = 0;
    status_stop = 1;
    @(negedge clk); #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_after_reset", cfg_stop, 0);

    // zero tests: straight to report
    setTests(0, 0, 0, 0, 0);
    runSeq(0, 0, 0, 0);
    check("zero_errors", lastErr, 0);
    check("zero_data", lastData, 0);

    // three passing tests, sub-word length truncated
    setTests(64, 100, 8192, 0, 0);
    runSeq(3, 0, 0, 0);
    check("three_data", lastData, 64'd8352);
    check("three_errors", lastErr, 0);
    check("three_rd_starts", rsCnt, 3);

    // write failure on test 2 of 4 skips its read
    setTests(32, 48, 17, 256, 0);
    tWrOk[1] = 1'b0;
    runSeq(4, 0, 0, 0);
    check("wrfail_errors", lastErr, 1);
    check("wrfail_pops", popCnt, 4);
    check("wrfail_rd_starts", rsCnt, 3);
    check("wrfail_data", lastData, 64'd352);

    // stop on error after a read failure on the first test
    setTests(40, 40, 40, 40, 40);
    tRdOk[0] = 1'b0;
    runSeq(5, 0, 1, 0);
    check("soe_pops", popCnt, 1);
    check("soe_errors", lastErr, 1);

    // write-only mode never reads
    setTests(15, 33, 0, 0, 0);
    tWrOk[0] = 1'b0;
    runSeq(2, 1, 0, 0);
    check("wronly_rd_starts", rsCnt, 0);
    check("wronly_data", lastData, 64'd32);
    check("wronly_errors", lastErr, 1);

    // read-only mode never writes
    setTests(48, 64, 0, 0, 0);
    tRdOk[1] = 1'b0;
    runSeq(2, 2, 0, 0);
    check("rdonly_wr_starts", wsCnt, 0);
    check("rdonly_errors", lastErr, 1);

    // mode 3 behaves as write+read
    setTests(16, 0, 0, 0, 0);
    runSeq(1, 3, 0, 0);
    check("mode3_rd_starts", rsCnt, 1);
    check("mode3_wr_starts", wsCnt, 1);

`ifdef SMI_FUZZ_WATCHDOG_EN
    // write completion never arrives: watchdog ends the test
    setTests(64, 0, 0, 0, 0);
    wrHang = 1;
    runSeq(1, 0, 0, 0);
    wrHang = 0;
    check("to_timeouts", lastTo, 1);
    check("to_errors", lastErr, 1);
    check("to_abort_delay", popCyc - wsCyc, 16);
`endif

    // reset while waiting for read completion
    setTests(64, 64, 0, 0, 0);
    runSeq(2, 0, 0, 1);
    @(negedge clk);
    rd_done_valid = 1'b0;
    status_stop = 1'b1;
    #1;
    check("in_wait_rd", rd_done_stop, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkResetOutputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_state_held", cfg_stop, 1);
    @(negedge clk); #1;
    check("idle_after_midrun_reset", cfg_stop, 0);
    check("no_status_after_reset", status_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
